// File: rtl/prg_chr_loader.sv
// ROM image loader: holds the CPU in reset, streams bytes into PRG then CHR,
// and passes the CPU/PPU buses straight through to the cart when idle.
module prg_chr_loader #(
    parameter int PRG_BITS       = 15,
    parameter int CHR_BITS       = 13,
    parameter int HOLD_CYCLES    = 16,
    parameter int RELEASE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 1 << 24
) (
    input  logic                clk_25,
    input  logic                rst,
    input  logic                start_in,
    input  logic [7:0]          byte_in,
    input  logic                byte_valid_in,
    output logic                byte_ready_out,
    input  logic [PRG_BITS-1:0] cpu_a_in,
    input  logic [7:0]          cpu_d_in,
    input  logic                cpu_r_nw_in,
    input  logic                cpu_prg_nce_in,
    input  logic [CHR_BITS-1:0] ppu_a_in,
    input  logic [7:0]          ppu_d_in,
    input  logic                ppu_r_nw_in,
    output logic [PRG_BITS-1:0] prg_a_out,
    output logic [7:0]          prg_d_out,
    output logic                prg_r_nw_out,
    output logic                prg_nce_out,
    output logic [CHR_BITS-1:0] chr_a_out,
    output logic [7:0]          chr_d_out,
    output logic                chr_r_nw_out,
    output logic                cpu_hold_out,
    output logic                busy_out,
    output logic                done_out,
    output logic                err_out,
    output logic [7:0]          checksum_out
);

    localparam int AW      = (PRG_BITS > CHR_BITS) ? PRG_BITS : CHR_BITS;
    localparam int HR_MAX  = (HOLD_CYCLES > RELEASE_CYCLES) ? HOLD_CYCLES : RELEASE_CYCLES;
    localparam int TMR_MAX = (HR_MAX > TIMEOUT_CYCLES) ? HR_MAX : TIMEOUT_CYCLES;
    localparam int TW      = $clog2(TMR_MAX + 1);

    localparam logic [AW-1:0] PRG_LAST = AW'((64'd1 << PRG_BITS) - 64'd1);
    localparam logic [AW-1:0] CHR_LAST = AW'((64'd1 << CHR_BITS) - 64'd1);
    localparam logic [TW-1:0] HOLD_END = TW'(HOLD_CYCLES);
    localparam logic [TW-1:0] REL_END  = TW'(RELEASE_CYCLES);
    localparam logic [TW-1:0] TO_END   = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_HOLD     = 3'd1;
    localparam logic [2:0] S_LOAD_PRG = 3'd2;
    localparam logic [2:0] S_LOAD_CHR = 3'd3;
    localparam logic [2:0] S_RELEASE  = 3'd4;

    logic [2:0]    state_q,   state_d;
    logic [AW-1:0] cnt_q,     cnt_d;
    logic [TW-1:0] tmr_q,     tmr_d;
    logic          wr_q,      wr_d;
    logic          wr_prg_q,  wr_prg_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [7:0]    sum_q,     sum_d;
    logic          err_q,     err_d;
    logic          done_q,    done_d;

    logic idle, loading, ready, accept, wr_prg, wr_chr;

    assign idle    = (state_q == S_IDLE);
    assign loading = (state_q == S_LOAD_PRG) || (state_q == S_LOAD_CHR);
    assign ready   = loading && !wr_q;
    assign accept  = ready && byte_valid_in;

    // tmr_q is shared: hold/release length in those states, idle gap while loading
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmr_d     = tmr_q;
        wr_d      = 1'b0;
        wr_prg_d  = wr_prg_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        sum_d     = sum_q;
        err_d     = err_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    sum_d   = '0;
                    err_d   = 1'b0;
                    tmr_d   = '0;
                end
            end
            S_HOLD: begin
                if (tmr_q == HOLD_END) begin
                    state_d = S_LOAD_PRG;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_LOAD_PRG, S_LOAD_CHR: begin
                if (accept) begin
                    wr_d      = 1'b1;
                    wr_prg_d  = (state_q == S_LOAD_PRG);
                    wr_addr_d = cnt_q;
                    wr_data_d = byte_in;
                    sum_d     = sum_q + byte_in;
                    tmr_d     = '0;
                    if (state_q == S_LOAD_PRG && cnt_q == PRG_LAST) begin
                        cnt_d   = '0;
                        state_d = S_LOAD_CHR;
                    end else if (state_q == S_LOAD_CHR && cnt_q == CHR_LAST) begin
                        cnt_d   = '0;
                        state_d = S_RELEASE;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end else if (tmr_q == TO_END) begin
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_RELEASE: begin
                if (tmr_q == REL_END) begin
                    state_d = S_IDLE;
                    done_d  = !err_q;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            tmr_q     <= '0;
            wr_q      <= 1'b0;
            wr_prg_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            sum_q     <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            wr_q      <= wr_d;
            wr_prg_q  <= wr_prg_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            sum_q     <= sum_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    // The write cycle can straddle a state change, so strobes follow wr_q, not state
    assign wr_prg = wr_q && wr_prg_q;
    assign wr_chr = wr_q && !wr_prg_q;

    assign prg_a_out    = idle ? cpu_a_in       : wr_addr_q[PRG_BITS-1:0];
    assign prg_d_out    = idle ? cpu_d_in       : wr_data_q;
    assign prg_r_nw_out = idle ? cpu_r_nw_in    : !wr_prg;
    assign prg_nce_out  = idle ? cpu_prg_nce_in : !wr_prg;
    assign chr_a_out    = idle ? ppu_a_in       : wr_addr_q[CHR_BITS-1:0];
    assign chr_d_out    = idle ? ppu_d_in       : wr_data_q;
    assign chr_r_nw_out = idle ? ppu_r_nw_in    : !wr_chr;

    assign byte_ready_out = ready;
    assign cpu_hold_out   = !idle;
    assign busy_out       = !idle;
    assign done_out       = done_q;
    assign err_out        = err_q;
    assign checksum_out   = sum_q;

endmodule
